// File: rtl/mdu_arbiter_pkg.sv
// Shared types for the MDU arbiter: operation codes, FSM states and default width.
// No logic; imported by the interface, the top and the bench.
// Backpressure: n/a.
package mdu_arbiter_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } mdu_state_t;

    localparam int MDU_DATA_W = 32;

endpackage

// File: rtl/mdu_arbiter_if.sv
// Command/result bundle between the arbiter (master) and the shared MDU (slave).
// Latency: wires only.
// Backpressure: none; the MDU must accept every start pulse and honour kill.
interface mdu_arbiter_if
    import mdu_arbiter_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W
);
    logic              mdu_start;
    mdu_op_t           mdu_op;
    logic [DATA_W-1:0] mdu_a;
    logic [DATA_W-1:0] mdu_b;
    logic              mdu_kill;
    logic              mdu_done;
    logic [DATA_W-1:0] mdu_hi;
    logic [DATA_W-1:0] mdu_lo;

    modport master (
        output mdu_start, mdu_op, mdu_a, mdu_b, mdu_kill,
        input  mdu_done, mdu_hi, mdu_lo
    );

    modport slave (
        input  mdu_start, mdu_op, mdu_a, mdu_b, mdu_kill,
        output mdu_done, mdu_hi, mdu_lo
    );

endinterface

// File: rtl/mdu_arbiter_result_slot.sv
// Per-slot HI/LO result holder with a done flag.
// Latency: load visible on outputs one cycle later.
// Backpressure: none; clear (flush) and ack (advance) both drop done, clear dominates.
module mdu_result_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic              ack,
    input  logic [DATA_W-1:0] in_hi,
    input  logic [DATA_W-1:0] in_lo,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    logic              done_q, done_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    always_comb begin
        done_d = done_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (load) begin
            hi_d   = in_hi;
            lo_d   = in_lo;
            done_d = 1'b1;
        end
        // hi/lo survive a clear; only the done flag is withdrawn
        if (clear || ack) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= done_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/mdu_arbiter.sv
// Sequences the shared MDU between execute slots 0 and 1; slot 0 (older) always wins.
// Latency: request seen in cycle t -> mdu_start t+1 -> ok the cycle after mdu_done.
// Backpressure: FU holds its request until ok; flush aborts in-flight work via mdu_kill.
module mdu_arbiter
    import mdu_arbiter_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              advance,
    input  logic              req0_valid,
    input  mdu_op_t           req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    input  mdu_op_t           req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              ok0,
    output logic              ok1,
    output logic [DATA_W-1:0] hi0,
    output logic [DATA_W-1:0] lo0,
    output logic [DATA_W-1:0] hi1,
    output logic [DATA_W-1:0] lo1,
    mdu_arbiter_if.master     mdu,
    output logic              busy
);

    mdu_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    mdu_op_t           op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;

    logic start, kill, load0, load1;
    logic done0, done1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        start   = 1'b0;
        kill    = 1'b0;
        load0   = 1'b0;
        load1   = 1'b0;
        case (state_q)
            IDLE: begin
                // a slot already holding its result is not reissued
                if (!flush) begin
                    if (req0_valid && !done0) begin
                        owner_d = 1'b0;
                        op_d    = req0_op;
                        a_d     = req0_a;
                        b_d     = req0_b;
                        state_d = ISSUE;
                    end else if (req1_valid && !done1) begin
                        owner_d = 1'b1;
                        op_d    = req1_op;
                        a_d     = req1_a;
                        b_d     = req1_b;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (flush) begin
                    kill    = 1'b1;
                    state_d = IDLE;
                end else begin
                    start   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // flush wins even over a coincident mdu_done
                if (flush) begin
                    kill    = 1'b1;
                    state_d = IDLE;
                end else if (mdu.mdu_done) begin
                    load0   = !owner_q;
                    load1   = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            op_q    <= MDU_MULT;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    mdu_result_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk   (clk),
        .reset (reset),
        .load  (load0),
        .clear (flush),
        .ack   (advance),
        .in_hi (mdu.mdu_hi),
        .in_lo (mdu.mdu_lo),
        .done  (done0),
        .hi    (hi0),
        .lo    (lo0)
    );

    mdu_result_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk   (clk),
        .reset (reset),
        .load  (load1),
        .clear (flush),
        .ack   (advance),
        .in_hi (mdu.mdu_hi),
        .in_lo (mdu.mdu_lo),
        .done  (done1),
        .hi    (hi1),
        .lo    (lo1)
    );

    assign mdu.mdu_start = start;
    assign mdu.mdu_kill  = kill;
    assign mdu.mdu_op    = op_q;
    assign mdu.mdu_a     = a_q;
    assign mdu.mdu_b     = b_q;

    assign ok0  = done0 & req0_valid;
    assign ok1  = done1 & req1_valid;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mdu_arbiter.sv
// Directed bench for mdu_arbiter with a fixed 3-cycle MDU model.
module tb_mdu_arbiter;
    import mdu_arbiter_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         advance = 1'b0;
    logic         req0_valid = 1'b0;
    mdu_op_t      req0_op = MDU_MULT;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req1_valid = 1'b0;
    mdu_op_t      req1_op = MDU_MULT;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         ok0, ok1, busy;
    logic [W-1:0] hi0, lo0, hi1, lo1;

    int total = 0;
    int bad = 0;

    mdu_arbiter_if #(.DATA_W(W)) mif ();

    mdu_arbiter #(.DATA_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .advance    (advance),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .ok0        (ok0),
        .ok1        (ok1),
        .hi0        (hi0),
        .lo0        (lo0),
        .hi1        (hi1),
        .lo1        (lo1),
        .mdu        (mif),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- MDU model: result 3 cycles after the start cycle ----------------
    int           cnt;
    logic         mdl_done;
    logic [W-1:0] mdl_hi, mdl_lo, pend_hi, pend_lo;
    logic         stale_done = 1'b0;
    logic [W-1:0] stale_hi = '0;
    logic [W-1:0] stale_lo = '0;

    function automatic logic [63:0] mdu_calc(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] qa, qb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        qa = a;
        qb = b;
        case (op)
            MDU_MULT:  return sa * sb;
            MDU_MULTU: return {32'd0, a} * {32'd0, b};
            MDU_DIV:   return (b == 32'd0) ? 64'd0 : {qa % qb, qa / qb};
            default:   return (b == 32'd0) ? 64'd0 : {a % b, a / b};
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= 0;
            mdl_done <= 1'b0;
            mdl_hi   <= '0;
            mdl_lo   <= '0;
            pend_hi  <= '0;
            pend_lo  <= '0;
        end else begin
            mdl_done <= 1'b0;
            if (mif.mdu_kill) begin
                cnt <= 0;
            end else if (mif.mdu_start) begin
                cnt <= 2;
                {pend_hi, pend_lo} <= mdu_calc(mif.mdu_op, mif.mdu_a, mif.mdu_b);
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    mdl_done <= 1'b1;
                    mdl_hi   <= pend_hi;
                    mdl_lo   <= pend_lo;
                end
            end
        end
    end

    assign mif.mdu_done = mdl_done | stale_done;
    assign mif.mdu_hi   = stale_done ? stale_hi : mdl_hi;
    assign mif.mdu_lo   = stale_done ? stale_lo : mdl_lo;

    // ---------------- checking helpers ----------------
    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic chko(input string tag, input logic [1:0] got, input logic [1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // advance is only legal while the arbiter is idle
    task automatic do_advance();
        chk1("adv_while_busy", busy, 1'b0);
        advance = 1'b1;
        cyc(1);
        advance = 1'b0;
    endtask

    initial begin
        // ---- reset state ----
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_start", mif.mdu_start, 1'b0);
        chk1("rst_kill", mif.mdu_kill, 1'b0);
        chk1("rst_ok0", ok0, 1'b0);
        chkw("rst_lo0", lo0, 32'd0);
        chkw("rst_a", mif.mdu_a, 32'd0);
        chko("rst_op", mif.mdu_op, MDU_MULT);
        cyc(1);
        reset = 1'b1;

        // ---- single multiply on slot 0: 7*6 ----
        cyc(1);
        req0_valid = 1'b1; req0_op = MDU_MULT; req0_a = 32'd7; req0_b = 32'd6;
        #1 chk1("mul_ok0_first", ok0, 1'b0);
        cyc(1); #1;
        chk1("mul_start", mif.mdu_start, 1'b1);
        chko("mul_op", mif.mdu_op, MDU_MULT);
        chkw("mul_a", mif.mdu_a, 32'd7);
        chkw("mul_b", mif.mdu_b, 32'd6);
        chk1("mul_busy", busy, 1'b1);
        req0_a = 32'd99;
        cyc(1); #1;
        chk1("mul_start_once", mif.mdu_start, 1'b0);
        cyc(2); #1;
        chk1("mul_ok0_at_done", ok0, 1'b0);
        cyc(1); #1;
        chk1("mul_ok0", ok0, 1'b1);
        chkw("mul_hi0", hi0, 32'd0);
        chkw("mul_lo0", lo0, 32'd42);
        chk1("mul_ok1", ok1, 1'b0);
        chk1("mul_idle", busy, 1'b0);
        cyc(1); #1;
        chk1("mul_no_reissue", busy, 1'b0);
        req0_valid = 1'b0;
        do_advance();

        // ---- divide on slot 1 alone: 100/7 ----
        req1_valid = 1'b1; req1_op = MDU_DIV; req1_a = 32'd100; req1_b = 32'd7;
        #1;
        cyc(1); #1;
        chk1("div_start", mif.mdu_start, 1'b1);
        chko("div_op", mif.mdu_op, MDU_DIV);
        chkw("div_a", mif.mdu_a, 32'd100);
        cyc(4); #1;
        chk1("div_ok1", ok1, 1'b1);
        chkw("div_hi1", hi1, 32'd2);
        chkw("div_lo1", lo1, 32'd14);
        chk1("div_ok0", ok0, 1'b0);
        chkw("div_lo0_held", lo0, 32'd42);
        req1_valid = 1'b0;
        do_advance();

        // ---- contention: MULTU 0xFFFFFFFF*2 on slot 0, DIVU 9/2 on slot 1 ----
        req0_valid = 1'b1; req0_op = MDU_MULTU; req0_a = 32'hFFFF_FFFF; req0_b = 32'd2;
        req1_valid = 1'b1; req1_op = MDU_DIVU;  req1_a = 32'd9;         req1_b = 32'd2;
        #1;
        cyc(1); #1;
        chk1("con_start0", mif.mdu_start, 1'b1);
        chko("con_op0", mif.mdu_op, MDU_MULTU);
        chkw("con_a0", mif.mdu_a, 32'hFFFF_FFFF);
        cyc(4); #1;
        chk1("con_ok0", ok0, 1'b1);
        chkw("con_hi0", hi0, 32'd1);
        chkw("con_lo0", lo0, 32'hFFFF_FFFE);
        chk1("con_ok1_early", ok1, 1'b0);
        chk1("con_gap", mif.mdu_start, 1'b0);
        cyc(1); #1;
        chk1("con_start1", mif.mdu_start, 1'b1);
        chko("con_op1", mif.mdu_op, MDU_DIVU);
        chkw("con_a1", mif.mdu_a, 32'd9);
        chkw("con_b1", mif.mdu_b, 32'd2);
        chk1("con_ok0_hold", ok0, 1'b1);
        cyc(4); #1;
        chk1("con_ok1", ok1, 1'b1);
        chkw("con_hi1", hi1, 32'd1);
        chkw("con_lo1", lo1, 32'd4);
        chk1("con_ok0_still", ok0, 1'b1);
        cyc(1); #1;
        chk1("con_idle", busy, 1'b0);
        do_advance();
        #1;
        chk1("con_adv_ok0", ok0, 1'b0);
        chk1("con_adv_ok1", ok1, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // ---- flush in BUSY coincident with mdu_done ----
        cyc(1);
        req0_valid = 1'b1; req0_op = MDU_MULT; req0_a = 32'd5; req0_b = 32'd5;
        cyc(1); #1;
        chk1("fb_start", mif.mdu_start, 1'b1);
        cyc(3);
        flush = 1'b1;
        req0_valid = 1'b0;
        #1;
        chk1("fb_done_seen", mif.mdu_done, 1'b1);
        chk1("fb_kill", mif.mdu_kill, 1'b1);
        chk1("fb_no_start", mif.mdu_start, 1'b0);
        cyc(1);
        flush = 1'b0;
        req0_valid = 1'b1; req0_op = MDU_MULT; req0_a = 32'd3; req0_b = 32'd3;
        #1;
        chk1("fb_ok0", ok0, 1'b0);
        chk1("fb_idle", busy, 1'b0);
        chk1("fb_kill_once", mif.mdu_kill, 1'b0);
        chkw("fb_lo0_kept", lo0, 32'hFFFF_FFFE);
        cyc(1); #1;
        chk1("fb_restart", mif.mdu_start, 1'b1);
        chkw("fb_a", mif.mdu_a, 32'd3);
        cyc(4); #1;
        chk1("fb_ok0_new", ok0, 1'b1);
        chkw("fb_hi0_new", hi0, 32'd0);
        chkw("fb_lo0_new", lo0, 32'd9);
        req0_valid = 1'b0;
        do_advance();

        // ---- flush in ISSUE ----
        req0_valid = 1'b1; req0_op = MDU_MULT; req0_a = 32'd2; req0_b = 32'd2;
        cyc(1);
        flush = 1'b1;
        #1;
        chk1("fi_no_start", mif.mdu_start, 1'b0);
        chk1("fi_kill", mif.mdu_kill, 1'b1);
        cyc(1);
        flush = 1'b0;
        req0_valid = 1'b0;
        #1;
        chk1("fi_idle", busy, 1'b0);
        chk1("fi_kill_once", mif.mdu_kill, 1'b0);
        req0_valid = 1'b1;
        #1;
        chk1("fi_ok0", ok0, 1'b0);
        chkw("fi_lo0_kept", lo0, 32'd9);
        req0_valid = 1'b0;

        // ---- asynchronous reset while BUSY ----
        cyc(1);
        req1_valid = 1'b1; req1_op = MDU_DIVU; req1_a = 32'd50; req1_b = 32'd3;
        cyc(2);
        #1 chk1("rb_busy_before", busy, 1'b1);
        #1 reset = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk1("rb_busy", busy, 1'b0);
        chk1("rb_start", mif.mdu_start, 1'b0);
        chk1("rb_kill", mif.mdu_kill, 1'b0);
        chkw("rb_lo0", lo0, 32'd0);
        chkw("rb_hi1", hi1, 32'd0);
        chkw("rb_lo1", lo1, 32'd0);
        chkw("rb_a", mif.mdu_a, 32'd0);
        chkw("rb_b", mif.mdu_b, 32'd0);
        cyc(1);
        reset = 1'b1;
        stale_done = 1'b1; stale_hi = 32'hDEAD_0000; stale_lo = 32'h0000_BEEF;
        cyc(1);
        stale_done = 1'b0;
        req1_valid = 1'b1;
        #1;
        chk1("rb_stale_ok1", ok1, 1'b0);
        chkw("rb_stale_hi1", hi1, 32'd0);
        chkw("rb_stale_lo1", lo1, 32'd0);
        cyc(1); #1;
        chk1("rb_restart", mif.mdu_start, 1'b1);
        cyc(4); #1;
        chk1("rb_ok1", ok1, 1'b1);
        chkw("rb_hi1_new", hi1, 32'd2);
        chkw("rb_lo1_new", lo1, 32'd16);
        req1_valid = 1'b0;
        do_advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
